// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: shift-add sequential multiplier driving an external combinational adder.
// Optional: define SEQ_MUL_ZERO_BYPASS_EN to finish zero-operand multiplies without stepping.
module seq_mul_ctrl #(
    parameter int unsigned WIDTH = 7
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     add_x,
    output logic [WIDTH-1:0]     add_y,
    input  logic [WIDTH:0]       add_s
);
    localparam int unsigned   CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_product;
    logic [CW-1:0]      r_cnt;
    logic               w_accept;
    logic               w_bypass;
    logic               w_last;
    logic [2*WIDTH-1:0] w_step;

    assign w_accept = (r_state == IDLE) && start;
    assign w_last   = (r_state == CALC) && (r_cnt == LAST);
    // Carry-out becomes the new MSB as the accumulator shifts right.
    assign w_step   = {add_s, r_acc[WIDTH-1:1]};

`ifdef SEQ_MUL_ZERO_BYPASS_EN
    assign w_bypass = (a == '0) || (b == '0);
`else
    assign w_bypass = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = w_bypass ? DONE : CALC;
            CALC:    if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        add_x = '0;
        add_y = '0;
        case (r_state)
            CALC: begin
                busy  = 1'b1;
                add_x = r_acc[2*WIDTH-1:WIDTH];
                add_y = r_acc[0] ? r_mcand : '0;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_acc   <= {{WIDTH{1'b0}}, b};
            r_cnt   <= '0;
            if (w_bypass) r_product <= '0;
        end else if (r_state == CALC) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CW'(1);
            if (w_last) r_product <= w_step;
        end
    end

    assign product = r_product;
endmodule

// File: tb/tb_seq_mul_ctrl.sv
// Self-checking bench for seq_mul_ctrl: directed scenarios plus randomized operands
// checked against plain-arithmetic product and latency expectations.
module tb_seq_mul_ctrl;
    localparam int W = 7;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;
    logic [W-1:0]   add_x;
    logic [W-1:0]   add_y;
    logic [W:0]     add_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external carry-lookahead adder.
    assign add_s = {1'b0, add_x} + {1'b0, add_y};

    seq_mul_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .product(product),
        .add_x  (add_x),
        .add_y  (add_y),
        .add_s  (add_s)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        return (2*W)'(x) * (2*W)'(y);
    endfunction

    // Edges after the accepting edge until done is visible.
    function automatic int exp_lat(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MUL_ZERO_BYPASS_EN
        if (x == '0 || y == '0) return 0;
`endif
        if (x == y + W'(1)) return W;
        return W;
    endfunction

    // Runs one multiply from IDLE; returns with the DUT back in IDLE. lat=-1 on timeout.
    task automatic do_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic [2*W-1:0] p, output bit busy_ok,
                          output bit carry_seen, output logic busy_after,
                          output logic done_after, output logic [2*W-1:0] p_after);
        start = 1'b1; a = x; b = y;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom);
        lat = -1; p = '0; busy_ok = 1'b1; carry_seen = 1'b0;
        for (int i = 0; i <= 4 * W; i++) begin
            if (i > 0) begin @(posedge clk); #1; end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (add_s[W] === 1'b1) carry_seen = 1'b1;
            if (done === 1'b1) begin lat = i; p = product; break; end
        end
        @(posedge clk); #1;
        busy_after = busy; done_after = done; p_after = product;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b1; a = 5; b = 3;
        repeat (3) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (product !== '0) begin bad++; $display("FAIL reset_product: got %0d want 0", product); end
        total++; if (add_x !== '0 || add_y !== '0) begin bad++; $display("FAIL reset_adder_ops: got x=%0d y=%0d want 0 0", add_x, add_y); end
        rst = 1'b0;
        @(posedge clk); #1;
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_edge_accept: busy got %b want 1", busy); end
        start = 1'b0;
        for (int i = 0; i < 4 * W && done !== 1'b1; i++) begin @(posedge clk); #1; end
        total++; if (done !== 1'b1 || product !== 14'd15) begin bad++; $display("FAIL reset_first_op: done=%b product=%0d want 1 15", done, product); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat; logic [2*W-1:0] p, pa; bit bok, cs; logic ba, da;
        do_mul(5, 3, lat, p, bok, cs, ba, da, pa);
        total++; if (lat != W) begin bad++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
        total++; if (p !== 14'd15) begin bad++; $display("FAIL basic_product: got %0d want 15", p); end
        total++; if (!bok) begin bad++; $display("FAIL basic_busy: busy dropped during op, want held 1"); end
        total++; if (ba !== 1'b0 || da !== 1'b0) begin bad++; $display("FAIL basic_idle_after: busy=%b done=%b want 0 0", ba, da); end
        total++; if (pa !== 14'd15) begin bad++; $display("FAIL basic_hold: product got %0d want 15", pa); end
        total++; if (add_x !== '0 || add_y !== '0) begin bad++; $display("FAIL idle_adder_ops: got x=%0d y=%0d want 0 0", add_x, add_y); end
    endtask

    task automatic test_carry();
        int lat; logic [2*W-1:0] p, pa; bit bok, cs; logic ba, da;
        do_mul(7'd127, 7'd127, lat, p, bok, cs, ba, da, pa);
        total++; if (p !== 14'd16129) begin bad++; $display("FAIL allones_product: got %0d want 16129", p); end
        total++; if (!cs) begin bad++; $display("FAIL allones_carry: add_s[%0d] never seen 1, want seen", W); end
        total++; if (lat != W) begin bad++; $display("FAIL allones_latency: got %0d want %0d", lat, W); end
    endtask

    task automatic test_ignore_start();
        int ndone = 0; int first = -1; logic [2*W-1:0] pd = '0;
        start = 1'b1; a = 5; b = 3;
        @(posedge clk); #1;
        a = 9; b = 9;
        for (int i = 0; i < 4 * W; i++) begin
            if (i == 3) start = 1'b0;
            @(posedge clk); #1;
            if (done === 1'b1) begin
                ndone++; pd = product;
                if (first < 0) first = i + 1;
            end
        end
        total++; if (ndone != 1) begin bad++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
        total++; if (pd !== 14'd15) begin bad++; $display("FAIL ignore_product: got %0d want 15", pd); end
        total++; if (first != W) begin bad++; $display("FAIL ignore_latency: got %0d want %0d", first, W); end
    endtask

    task automatic test_reset_mid();
        int ndone = 0; int lat; logic [2*W-1:0] p, pa; bit bok, cs; logic ba, da;
        start = 1'b1; a = 100; b = 50;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (product !== '0) begin bad++; $display("FAIL midrst_product: got %0d want 0", product); end
        for (int i = 0; i < 2 * W; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk); #1;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL midrst_no_done: got %0d pulses want 0", ndone); end
        do_mul(6, 7, lat, p, bok, cs, ba, da, pa);
        total++; if (p !== 14'd42 || lat != W) begin bad++; $display("FAIL midrst_next_op: product=%0d lat=%0d want 42 %0d", p, lat, W); end
    endtask

    task automatic test_zero();
        int lat; logic [2*W-1:0] p, pa; bit bok, cs; logic ba, da;
        do_mul(0, 77, lat, p, bok, cs, ba, da, pa);
        total++; if (p !== '0) begin bad++; $display("FAIL zero_a_product: got %0d want 0", p); end
        total++; if (lat != exp_lat(0, 77)) begin bad++; $display("FAIL zero_a_latency: got %0d want %0d", lat, exp_lat(0, 77)); end
        do_mul(45, 0, lat, p, bok, cs, ba, da, pa);
        total++; if (p !== '0 || lat != exp_lat(45, 0)) begin bad++; $display("FAIL zero_b: product=%0d lat=%0d want 0 %0d", p, lat, exp_lat(45, 0)); end
    endtask

    task automatic test_back_to_back();
        logic [2*W-1:0] q[$];
        logic [2*W-1:0] e;
        int ndone = 0; int idle = 0; int nacc = 0; logic pb = 1'b0;
        start = 1'b1; a = W'($urandom_range(1, 127)); b = W'($urandom_range(1, 127));
        for (int i = 0; i < 20 * W && ndone < 4; i++) begin
            @(posedge clk); #1;
            if (busy === 1'b1 && pb !== 1'b1) begin
                q.push_back(ref_mul(a, b));
                if (nacc > 0) begin
                    total++; if (idle != 1) begin bad++; $display("FAIL b2b_idle_gap: got %0d cycles want 1", idle); end
                end
                nacc++;
                a = W'($urandom_range(1, 127)); b = W'($urandom_range(1, 127));
            end
            if (busy !== 1'b1) idle++;
            if (done === 1'b1) begin
                e = (q.size() > 0) ? q.pop_front() : '1;
                total++; if (product !== e) begin bad++; $display("FAIL b2b_product: got %0d want %0d", product, e); end
                ndone++; idle = 0;
            end
            pb = busy;
        end
        start = 1'b0;
        total++; if (ndone != 4) begin bad++; $display("FAIL b2b_done_count: got %0d want 4", ndone); end
        for (int i = 0; i < 4 * W && busy === 1'b1; i++) begin @(posedge clk); #1; end
    endtask

    task automatic test_random();
        int lat; logic [2*W-1:0] p, pa; bit bok, cs; logic ba, da;
        logic [W-1:0] x, y;
        for (int n = 0; n < 24; n++) begin
            x = W'($urandom); y = W'($urandom);
            case ($urandom_range(0, 5))
                0: x = '0;
                1: y = '0;
                2: begin x = '1; y = W'($urandom_range(64, 127)); end
                default: ;
            endcase
            do_mul(x, y, lat, p, bok, cs, ba, da, pa);
            total++; if (p !== ref_mul(x, y)) begin bad++; $display("FAIL rand_product %0d*%0d: got %0d want %0d", x, y, p, ref_mul(x, y)); end
            total++; if (lat != exp_lat(x, y)) begin bad++; $display("FAIL rand_latency %0d*%0d: got %0d want %0d", x, y, lat, exp_lat(x, y)); end
            total++; if (!bok || ba !== 1'b0 || pa !== ref_mul(x, y)) begin bad++; $display("FAIL rand_busy_hold %0d*%0d: busy_ok=%0d busy_after=%b product_after=%0d want 1 0 %0d", x, y, bok, ba, pa, ref_mul(x, y)); end
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_mid();
        test_zero();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/seq_mul_ctrl.md
SEQ_MUL_CTRL -- requirements
Module: seq_mul_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 7, setting the operand width in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request to begin a multiply.
REQ-005 SHALL have ports a and b, input, WIDTH bits each: multiplicand and multiplier, unsigned.
REQ-006 SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-007 SHALL have port done, output, 1 bit: one-cycle completion strobe.
REQ-008 SHALL have port product, output, 2*WIDTH bits: unsigned result.
REQ-009 SHALL have ports add_x and add_y, output, WIDTH bits each: operands driven to the external combinational carry-lookahead adder.
REQ-010 SHALL have port add_s, input, WIDTH+1 bits: sum from that adder, with add_s[WIDTH] as carry-out, returned in the same cycle.

Function
REQ-011 SHALL implement the states IDLE, CALC and DONE.
REQ-012 SHALL accept start only in IDLE, latching a into the multiplicand register, b into the low half of the accumulator, clearing the high half and the step counter, and entering CALC.
REQ-013 SHALL ignore start in CALC and DONE, with no effect on latched operands or the result.
REQ-014 SHALL perform one shift-add step per CALC cycle:
- add_x = accumulator high half.
- add_y = multiplicand if accumulator bit 0 is 1, else 0.
- The accumulator loads {add_s, accumulator low half} shifted right by one.
REQ-015 SHALL perform exactly WIDTH steps, then enter DONE.
REQ-016 SHALL drive add_x and add_y to 0 outside CALC.
REQ-017 SHALL hold busy high in CALC and DONE and low in IDLE.
REQ-018 SHALL raise done high for exactly the one DONE cycle, which follows the WIDTH-th edge after the accepting edge, then return to IDLE.
REQ-019 SHALL update product only on entry to DONE and hold it until the next completion, so that it remains valid during and after done.
REQ-020 SHALL produce product equal to a*b exactly, with no truncation, for all operands including all-ones.
REQ-021 SHALL accept back-to-back operations: start sampled high in the IDLE cycle directly after DONE is accepted.

Reset
REQ-022 SHALL, with rst high at a clock edge, enter IDLE and clear busy, done, product, accumulator, multiplicand and counter to 0, overriding start.
REQ-023 SHALL abandon any in-progress operation on a reset asserted mid-operation, with no done pulse and product reading 0.
REQ-024 SHALL accept start on the first edge with rst low.

Configuration
REQ-025 SHALL support macro SEQ_MUL_ZERO_BYPASS_EN.
REQ-026 SHALL, with SEQ_MUL_ZERO_BYPASS_EN defined, go directly from IDLE to DONE when a start is accepted with a==0 or b==0, so that product is 0 and done is high the cycle after the accepting edge.
REQ-027 SHALL, without SEQ_MUL_ZERO_BYPASS_EN, give zero operands the full WIDTH-step latency.

Verification
REQ-028 SHALL cover: WIDTH=7, a=5, b=3, start one cycle -> busy high; done high only after the 7th edge following acceptance; product=15.
REQ-029 SHALL cover: a=127, b=127 -> product=16129; the carry-out path via add_s[7] is exercised.
REQ-030 SHALL cover: start re-asserted with a=9, b=9 during CALC of 5*3 -> ignored; product=15; one done pulse.
REQ-031 SHALL cover: rst pulsed at step 4 of 100*50 -> next cycle busy=0, product=0, no done; a following 6*7 yields 42.
REQ-032 SHALL cover: a=0, b=77 -> product=0; done after 7 steps without the macro, or 1 edge after acceptance with SEQ_MUL_ZERO_BYPASS_EN.
REQ-033 SHALL cover: start held high continuously -> operations repeat with one IDLE cycle between done and the next busy period.
